// File: rtl/prog_loader.sv
// prog_loader: framed stream loader that writes program memory, checks an XOR checksum and gates the CPU
module prog_loader #(
   parameter int DATA_W  = 32,
   parameter int ADDR_W  = 11,
   parameter int COUNT_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              w_enable,
   output logic [ADDR_W-1:0] w_adrs,
   output logic [DATA_W-1:0] w_instruction,
   output logic              cpu_en,
   output logic              busy,
   output logic              err,
   output logic [15:0]       words_written
);
   typedef enum logic [2:0] {IDLE, HDR, DATA, CSUM, RUN, ERR} state_t;
   state_t state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d, w_adrs_q, w_adrs_d;
   logic [COUNT_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0]  csum_q, csum_d, w_instr_q, w_instr_d;
   logic [15:0]        ww_q, ww_d;
   logic               w_en_q, w_en_d, rdy_q, rdy_d, cpu_q, cpu_d, err_q, err_d;
   logic               acc;
   logic [COUNT_W-1:0] hdr_count;
   assign acc       = in_valid && rdy_q;
   assign hdr_count = in_data[DATA_W-1 -: COUNT_W];
   // next-state and next-output logic; outputs are derived from the next state so they come out registered
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      csum_d    = csum_q;
      ww_d      = ww_q;
      w_en_d    = 1'b0;
      w_adrs_d  = w_adrs_q;
      w_instr_d = w_instr_q;
      unique case (state_q)
         IDLE, RUN, ERR: if (start) begin
            state_d = HDR;
            csum_d  = '0;
            ww_d    = '0;
         end
         HDR: if (acc) begin
            if (hdr_count != '0) begin
               addr_d  = in_data[ADDR_W-1:0];
               rem_d   = hdr_count;
               state_d = DATA;
            end else begin
               state_d = CSUM;
            end
         end
         DATA: if (acc) begin
            w_en_d    = 1'b1;
            w_adrs_d  = addr_q;
            w_instr_d = in_data;
            csum_d    = csum_q ^ in_data;
            addr_d    = addr_q + ADDR_W'(1);
            rem_d     = rem_q - COUNT_W'(1);
            ww_d      = (&ww_q) ? ww_q : ww_q + 16'd1;
            state_d   = (rem_q == COUNT_W'(1)) ? HDR : DATA;
         end
         CSUM: if (acc) state_d = (in_data == csum_q) ? RUN : ERR;
         default: state_d = IDLE;
      endcase
      rdy_d = state_d inside {HDR, DATA, CSUM};
      cpu_d = state_d == RUN;
      err_d = state_d == ERR;
   end
   // state and output registers; reset aborts any session at once
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         csum_q    <= '0;
         ww_q      <= '0;
         w_en_q    <= 1'b0;
         w_adrs_q  <= '0;
         w_instr_q <= '0;
         rdy_q     <= 1'b0;
         cpu_q     <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         csum_q    <= csum_d;
         ww_q      <= ww_d;
         w_en_q    <= w_en_d;
         w_adrs_q  <= w_adrs_d;
         w_instr_q <= w_instr_d;
         rdy_q     <= rdy_d;
         cpu_q     <= cpu_d;
         err_q     <= err_d;
      end
   end
   assign in_ready      = rdy_q;
   assign busy          = rdy_q;
   assign w_enable      = w_en_q;
   assign w_adrs        = w_adrs_q;
   assign w_instruction = w_instr_q;
   assign cpu_en        = cpu_q;
   assign err           = err_q;
   assign words_written = ww_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader
module tb_prog_loader;
   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        w_enable;
   logic [10:0] w_adrs;
   logic [31:0] w_instruction;
   logic        cpu_en, busy, err;
   logic [15:0] words_written;
   int checks = 0;
   int failures = 0;

   prog_loader dut (
      .clk(clk), .resetn(resetn), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .w_enable(w_enable), .w_adrs(w_adrs), .w_instruction(w_instruction),
      .cpu_en(cpu_en), .busy(busy), .err(err), .words_written(words_written)
   );

   always #5 clk = ~clk;

   // present a word and return at the falling edge after it was accepted; in_valid stays high
   task automatic send(input logic [31:0] w);
      int n = 0;
      in_valid = 1'b1;
      in_data  = w;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_timeout word=%h in_ready=%b required 1", w, in_ready);
      end
      @(negedge clk);
   endtask

   task automatic pulse_start();
      in_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic expect_write(input string name, input logic [10:0] a, input logic [31:0] d);
      checks++;
      if ({w_enable, w_adrs, w_instruction} !== {1'b1, a, d}) begin
         failures++;
         $display("FAIL %s got en=%b adrs=%0d data=%h required en=1 adrs=%0d data=%h",
                  name, w_enable, w_adrs, w_instruction, a, d);
      end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({in_ready, busy, w_enable, w_adrs, w_instruction, cpu_en, err, words_written} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got rdy=%b busy=%b wen=%b adrs=%0d data=%h cpu=%b err=%b ww=%0d required all 0",
                  in_ready, busy, w_enable, w_adrs, w_instruction, cpu_en, err, words_written);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, cpu_en} !== 3'b000) begin
         failures++;
         $display("FAIL idle_after_reset got rdy=%b busy=%b cpu=%b required 000", in_ready, busy, cpu_en);
      end
   endtask

   task automatic test_single_words();
      pulse_start();
      checks++;
      if ({in_ready, busy} !== 2'b11) begin
         failures++;
         $display("FAIL start_to_hdr got rdy=%b busy=%b required 11", in_ready, busy);
      end
      send(32'h0100_000F);
      checks++;
      if (w_enable !== 1'b0) begin
         failures++;
         $display("FAIL hdr_no_write got w_enable=%b required 0", w_enable);
      end
      send(32'hFFFF_0000);
      expect_write("single_w0", 11'd15, 32'hFFFF_0000);
      send(32'h0100_0011);
      checks++;
      if ({w_enable, w_adrs, w_instruction} !== {1'b0, 11'd15, 32'hFFFF_0000}) begin
         failures++;
         $display("FAIL hold_on_hdr got en=%b adrs=%0d data=%h required en=0 adrs=15 data=ffff0000",
                  w_enable, w_adrs, w_instruction);
      end
      send(32'hAAAA_AAAA);
      expect_write("single_w1", 11'd17, 32'hAAAA_AAAA);
      send(32'h0000_0000);
      checks++;
      if ({w_enable, cpu_en, busy} !== 3'b001) begin
         failures++;
         $display("FAIL end_hdr got wen=%b cpu=%b busy=%b required 001", w_enable, cpu_en, busy);
      end
      send(32'h5555_AAAA);
      in_valid = 1'b0;
      checks++;
      if ({cpu_en, err, busy, in_ready, w_enable, words_written} !== {5'b10000, 16'd2}) begin
         failures++;
         $display("FAIL single_run got cpu=%b err=%b busy=%b rdy=%b wen=%b ww=%0d required 1 0 0 0 0 2",
                  cpu_en, err, busy, in_ready, w_enable, words_written);
      end
   endtask

   task automatic test_burst_stall();
      pulse_start();
      checks++;
      if ({cpu_en, busy} !== 2'b01) begin
         failures++;
         $display("FAIL reload_a got cpu=%b busy=%b required 01", cpu_en, busy);
      end
      send(32'h0300_0001);
      send(32'h0000_0011);
      expect_write("burst_w0", 11'd1, 32'h11);
      send(32'h0000_0022);
      expect_write("burst_w1", 11'd2, 32'h22);
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++;
         if ({w_enable, in_ready} !== 2'b01) begin
            failures++;
            $display("FAIL stall_%0d got wen=%b rdy=%b required 01", i, w_enable, in_ready);
         end
      end
      send(32'h0000_0033);
      expect_write("burst_w2", 11'd3, 32'h33);
      send(32'h0000_0000);
      send(32'h0000_0000);
      in_valid = 1'b0;
      checks++;
      if ({cpu_en, err, words_written} !== {2'b10, 16'd3}) begin
         failures++;
         $display("FAIL burst_run got cpu=%b err=%b ww=%0d required 1 0 3", cpu_en, err, words_written);
      end
   endtask

   task automatic test_mismatch();
      pulse_start();
      send(32'h0100_000F);
      send(32'hFFFF_0000);
      send(32'h0100_0011);
      send(32'hAAAA_AAAA);
      send(32'h0000_0000);
      send(32'h0000_0000);
      in_valid = 1'b0;
      checks++;
      if ({err, cpu_en, busy, in_ready} !== 4'b1000) begin
         failures++;
         $display("FAIL mismatch got err=%b cpu=%b busy=%b rdy=%b required 1000", err, cpu_en, busy, in_ready);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b1) begin
         failures++;
         $display("FAIL err_sticky got err=%b required 1", err);
      end
      pulse_start();
      checks++;
      if ({err, in_ready, words_written} !== {2'b01, 16'd0}) begin
         failures++;
         $display("FAIL err_clear got err=%b rdy=%b ww=%0d required 0 1 0", err, in_ready, words_written);
      end
   endtask

   task automatic test_wrap();
      send(32'h0200_07FF);
      send(32'hDEAD_BEEF);
      expect_write("wrap_top", 11'd2047, 32'hDEAD_BEEF);
      send(32'h1234_5678);
      expect_write("wrap_zero", 11'd0, 32'h1234_5678);
      send(32'h0000_0000);
      send(32'hCC99_E897);
      in_valid = 1'b0;
      checks++;
      if ({cpu_en, err, words_written} !== {2'b10, 16'd2}) begin
         failures++;
         $display("FAIL wrap_run got cpu=%b err=%b ww=%0d required 1 0 2", cpu_en, err, words_written);
      end
   endtask

   task automatic test_reload();
      pulse_start();
      checks++;
      if ({cpu_en, busy} !== 2'b01) begin
         failures++;
         $display("FAIL reload_b got cpu=%b busy=%b required 01", cpu_en, busy);
      end
      send(32'h0300_0064);
      send(32'h0000_0001);
      expect_write("reload_w0", 11'd100, 32'h1);
      pulse_start();
      checks++;
      if ({in_ready, busy, cpu_en, w_enable} !== 4'b1100) begin
         failures++;
         $display("FAIL start_in_data got rdy=%b busy=%b cpu=%b wen=%b required 1100", in_ready, busy, cpu_en, w_enable);
      end
      send(32'h0000_0002);
      expect_write("reload_w1", 11'd101, 32'h2);
      send(32'h0000_0003);
      expect_write("reload_w2", 11'd102, 32'h3);
      send(32'h0100_00C8);
      send(32'h0000_0004);
      expect_write("reload_w3", 11'd200, 32'h4);
      send(32'h0000_0000);
      send(32'h0000_0004);
      in_valid = 1'b0;
      checks++;
      if ({cpu_en, err, words_written} !== {2'b10, 16'd4}) begin
         failures++;
         $display("FAIL reload_run got cpu=%b err=%b ww=%0d required 1 0 4", cpu_en, err, words_written);
      end
   endtask

   task automatic test_async_reset();
      pulse_start();
      send(32'h0200_0032);
      send(32'h0000_0007);
      expect_write("pre_reset_w", 11'd50, 32'h7);
      in_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if ({in_ready, busy, w_enable, w_adrs, w_instruction, cpu_en, err, words_written} !== '0) begin
         failures++;
         $display("FAIL async_reset got rdy=%b busy=%b wen=%b adrs=%0d data=%h cpu=%b err=%b ww=%0d required all 0",
                  in_ready, busy, w_enable, w_adrs, w_instruction, cpu_en, err, words_written);
      end
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      checks++;
      if ({in_ready, busy, cpu_en} !== 3'b000) begin
         failures++;
         $display("FAIL post_reset_idle got rdy=%b busy=%b cpu=%b required 000", in_ready, busy, cpu_en);
      end
      pulse_start();
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL post_reset_start got rdy=%b required 1", in_ready);
      end
   endtask

   initial begin
      test_reset();
      test_single_words();
      test_burst_stall();
      test_mismatch();
      test_wrap();
      test_reload();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised boot/program loader that owns the CPU program-load port and the CPU enable.
- Accepts a framed stream of header and data words over a valid/ready handshake, writes the words into the unified instruction/data memory, and verifies an XOR checksum.
- Releases the CPU only when the image is complete and the checksum matches.
- Sits between the external load source and top_level, replacing hand-driven w_enable/w_adrs/w_instruction/cpu_en sequencing.

Parameters:
DATA_W, 32, memory word width and stream word width
ADDR_W, 11, memory address width (matches w_adrs)
COUNT_W, 8, burst-length field width in the header word; must satisfy COUNT_W + ADDR_W <= DATA_W

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; begins a load session
in_valid  input  1  stream word valid
in_ready  output  1  loader can accept a stream word
in_data  input  DATA_W  stream word (header, data or checksum)
w_enable  output  1  memory write strobe to top_level
w_adrs  output  ADDR_W  memory write address
w_instruction  output  DATA_W  memory write data
cpu_en  output  1  CPU run enable
busy  output  1  high in HDR, DATA, CSUM
err  output  1  checksum mismatch, sticky until next start
words_written  output  16  data words written this session, saturating at 16'hFFFF

Behaviour:
- Reset values of all outputs: 0. Reset state: IDLE. Reset clears the checksum accumulator and the burst counter.
- Reset asserted mid-load aborts the session immediately; cpu_en stays 0; partial memory contents are not undone.
- Handshake: a word is accepted on a rising edge with in_valid && in_ready.
  - in_ready = 1 only in HDR, DATA and CSUM.
  - in_ready is a registered output; it does not depend combinationally on in_valid.
- Header word fields:
  - base = in_data[ADDR_W-1:0].
  - count = in_data[DATA_W-1:DATA_W-COUNT_W].
  - Other bits are ignored.
  - count = 0 marks end of image.
- State machine:
  - IDLE: on start -> HDR; cpu_en <= 0; err <= 0; checksum <= 0; words_written <= 0.
  - HDR, accept with count != 0: latch base into the address register and count into the remaining counter -> DATA.
  - HDR, accept with count == 0 -> CSUM.
  - DATA, accept: issue a write, checksum ^= in_data, address += 1, remaining -= 1. After the last word -> HDR.
  - CSUM, accept: if in_data == checksum -> RUN, else -> ERR.
  - RUN: cpu_en = 1. start -> HDR (reload); cpu_en drops to 0 the cycle after the start pulse.
  - ERR: err = 1, cpu_en = 0. start -> HDR.
- Start pulses in HDR, DATA or CSUM are ignored.
- Write timing:
  - For a data word accepted at edge N, w_enable=1 with w_adrs and w_instruction valid for exactly the cycle after edge N (1-cycle latency).
  - Back-to-back accepts give back-to-back writes at consecutive addresses.
  - w_enable is 0 for header and checksum words.
  - w_adrs and w_instruction hold their last values when w_enable = 0.
- Address arithmetic:
  - Increments modulo 2^ADDR_W.
  - A burst crossing the top address wraps to 0 silently.
  - Address increments apply within a burst only; each header reloads the base.
- Checksum: XOR of all data words in the session. Header and checksum words are excluded.
- in_valid low stalls any state without side effects; in_ready stays asserted.
- words_written increments on each issued write and saturates at 16'hFFFF.

Test Plan:
- Single-word bursts: start; header {count=1, base=15}, data FFFF_0000; header {count=1, base=17}, data AAAA_AAAA; header count=0; checksum 5555_AAAA -> writes (15,FFFF0000) and (17,AAAAAAAA); cpu_en=1 one cycle after checksum accept; err=0; words_written=2.
- Burst with stall: header {count=3, base=1}, data 11,22,33 with in_valid low for 2 cycles between 22 and 33 -> writes at 1,2,3; no write during stall; after end header, checksum 00 accepted (11^22^33 = 00) -> RUN.
- Checksum mismatch: image as in first case, checksum 0000_0000 -> err=1, cpu_en=0, state ERR; a following start clears err and in_ready=1 next cycle.
- Address wrap: header {count=2, base=2047} -> writes at 2047 then 0.
- Reload: in RUN, pulse start -> cpu_en=0 next cycle, busy=1; start pulse during DATA ignored (remaining count unchanged).
- Async reset mid-burst: resetn low between data words -> all outputs 0 immediately without a clock edge; after release, state IDLE, in_ready=0.
